// File: rtl/line_streamer.sv
// line_streamer: double-buffered scanline store feeding a pixel stream.
// A producer fills two banks alternately; VGA timing drains them pixel by
// pixel. If no line is ready at line_start, black is sent and underrun latches.
module line_streamer #(
  parameter int N_PIXELS = 480,
  parameter int CW       = 12
) (
  input  logic                   CLK100MHZ,
  input  logic                   ck_rst,
  input  logic                   line_valid,
  input  logic [N_PIXELS*CW-1:0] line_data,
  output logic                   line_ready,
  output logic                   req_line,
  input  logic                   line_start,
  input  logic                   pix_en,
  output logic [CW-1:0]          pix_color,
  output logic                   pix_valid,
  output logic                   underrun,
  output logic                   sync_err
);

  localparam int              CNT_W = (N_PIXELS > 1) ? $clog2(N_PIXELS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, STREAM, BLANK} state_e;

  state_e                           state_q, state_d;
  logic [1:0][N_PIXELS-1:0][CW-1:0] bank_q, bank_d;
  logic [1:0]                       full_q, full_d;
  logic                             wbank_q, wbank_d;
  logic                             rbank_q, rbank_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [CW-1:0]                    pix_color_q, pix_color_d;
  logic                             pix_valid_q, pix_valid_d;
  logic                             req_line_q, req_line_d;
  logic                             underrun_q, underrun_d;
  logic                             sync_err_q, sync_err_d;
  logic                             init_q, init_d;

  logic accept;
  logic active;
  logic release_bank;

  // Ready is gated by reset so nothing is accepted while the flags are held clear.
  assign line_ready   = !full_q[wbank_q] && !ck_rst;
  assign accept       = line_valid && line_ready;
  assign active       = (state_q == STREAM) || (state_q == BLANK);
  // Only a streamed line frees a bank; BLANK never touches storage.
  assign release_bank = (state_q == STREAM) && pix_en && (cnt_q == LAST);

  assign pix_color = pix_color_q;
  assign pix_valid = pix_valid_q;
  assign req_line  = req_line_q;
  assign underrun  = underrun_q;
  assign sync_err  = sync_err_q;

  // Read FSM state register.
  always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
    if (ck_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Read FSM next state: a line runs to its last pixel; line_start mid-line is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:          if (line_start) state_d = full_q[rbank_q] ? STREAM : BLANK;
      STREAM, BLANK: if (pix_en && (cnt_q == LAST)) state_d = IDLE;
      default:       state_d = IDLE;
    endcase
  end

  // Read FSM outputs: pixel register, counter and sticky error flags.
  always_comb begin
    cnt_d       = cnt_q;
    pix_color_d = pix_color_q;
    pix_valid_d = 1'b0;
    underrun_d  = underrun_q;
    sync_err_d  = sync_err_q;
    case (state_q)
      IDLE: begin
        if (line_start) begin
          cnt_d = '0;
          if (!full_q[rbank_q]) underrun_d = 1'b1;
        end
      end
      STREAM, BLANK: begin
        if (line_start) sync_err_d = 1'b1;
        if (pix_en) begin
          pix_valid_d = 1'b1;
          pix_color_d = (state_q == STREAM) ? bank_q[rbank_q][cnt_q] : '0;
          cnt_d       = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Bank bookkeeping: accept and release can hit different banks on one edge.
  always_comb begin
    bank_d  = bank_q;
    full_d  = full_q;
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    if (accept) begin
      bank_d[wbank_q] = line_data;
      full_d[wbank_q] = 1'b1;
      wbank_d         = ~wbank_q;
    end
    if (release_bank) begin
      full_d[rbank_q] = 1'b0;
      rbank_d         = ~rbank_q;
    end
  end

  // Line request: first edge out of reset, a freed bank, or a fill that leaves the other bank empty.
  always_comb begin
    init_d     = 1'b1;
    req_line_d = !init_q || release_bank || (accept && !full_q[~wbank_q]);
  end

  // Control and output registers, all cleared asynchronously.
  always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
    if (ck_rst) begin
      full_q      <= '0;
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      cnt_q       <= '0;
      pix_color_q <= '0;
      pix_valid_q <= 1'b0;
      req_line_q  <= 1'b0;
      underrun_q  <= 1'b0;
      sync_err_q  <= 1'b0;
      init_q      <= 1'b0;
    end else begin
      full_q      <= full_d;
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      cnt_q       <= cnt_d;
      pix_color_q <= pix_color_d;
      pix_valid_q <= pix_valid_d;
      req_line_q  <= req_line_d;
      underrun_q  <= underrun_d;
      sync_err_q  <= sync_err_d;
      init_q      <= init_d;
    end
  end

  // Bank storage; contents are guarded by the full flags, so no reset needed.
  always_ff @(posedge CLK100MHZ) begin
    bank_q <= bank_d;
  end

endmodule
